// File: rtl/pixel_seq_readout.sv
// Frame sequencer for the pixel array: erase/expose/convert strobes, ADC ramp code,
// one-hot per-row read strobes and a valid/ready stream of captured rows.
module pixel_seq_readout #(
   parameter int ROWS      = 2,
   parameter int COLS      = 2,
   parameter int DW        = 8,
   parameter int ERASE_CYC = 5,
   parameter int READ_CYC  = 2,
   localparam int RW       = (ROWS > 1) ? $clog2(ROWS) : 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 continuous,
   input  logic [15:0]          expose_cycles,
   output logic                 erase,
   output logic                 expose,
   output logic                 convert,
   output logic [DW-1:0]        ramp_code,
   output logic [ROWS-1:0]      read,
   input  logic [COLS*DW-1:0]   pix_data,
   output logic [COLS*DW-1:0]   data_out,
   output logic [RW-1:0]        row_idx,
   output logic                 data_valid,
   input  logic                 data_ready,
   output logic                 busy,
   output logic                 frame_done,
   output logic [15:0]          frame_cnt
);

   localparam int M1   = (ERASE_CYC > READ_CYC) ? ERASE_CYC : READ_CYC;
   localparam int M2   = (M1 > (1 << DW)) ? M1 : (1 << DW);
   localparam int MAXC = (M2 > 65535) ? M2 : 65535;
   localparam int CW   = $clog2(MAXC + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_ERASE, S_EXPOSE, S_CONVERT, S_READ, S_XFER, S_DONE
   } state_t;

   state_t        state, state_nx;
   logic [CW-1:0] cnt;
   logic [15:0]   exp_len;
   logic [RW-1:0] row;
   logic          phase_last;
   logic          row_last;

   // End of the timed phase currently running; cnt restarts at 0 on every state change.
   always_comb begin
      phase_last = 1'b0;
      case (state)
         S_ERASE:   phase_last = (cnt == CW'(ERASE_CYC - 1));
         S_EXPOSE:  phase_last = (cnt == CW'(exp_len) - CW'(1));
         S_CONVERT: phase_last = (cnt == CW'((1 << DW) - 1));
         S_READ:    phase_last = (cnt == CW'(READ_CYC - 1));
         default:   phase_last = 1'b0;
      endcase
   end

   assign row_last = (row == RW'(ROWS - 1));

   always_comb begin
      // NOTE: default assigned first so every path drives state_nx and no latch is inferred.
      state_nx = state;
      case (state)
         S_IDLE:    if (start || continuous) state_nx = S_ERASE;
         S_ERASE:   if (phase_last) state_nx = S_EXPOSE;
         S_EXPOSE:  if (phase_last) state_nx = S_CONVERT;
         S_CONVERT: if (phase_last) state_nx = S_READ;
         S_READ:    if (phase_last) state_nx = S_XFER;
         S_XFER:    if (data_ready) state_nx = row_last ? S_DONE : S_READ;
         S_DONE:    state_nx = continuous ? S_ERASE : S_IDLE;
         default:   state_nx = S_IDLE;
      endcase
   end

   // NOTE: clocked blocks use non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nx;
   end

   // NOTE: the captured row is reset too, because every output must read 0 during reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt       <= '0;
         exp_len   <= 16'd1;
         row       <= '0;
         data_out  <= '0;
         row_idx   <= '0;
         frame_cnt <= 16'd0;
      end else begin
         if (state_nx != state)
            cnt <= '0;
         else if (state inside {S_ERASE, S_EXPOSE, S_CONVERT, S_READ})
            cnt <= cnt + CW'(1);

         if (state_nx == S_ERASE && state != S_ERASE)
            exp_len <= (expose_cycles == 16'd0) ? 16'd1 : expose_cycles;

         if (state == S_CONVERT)
            row <= '0;
         else if (state == S_XFER && data_ready && !row_last)
            row <= row + RW'(1);

         if (state == S_READ && phase_last) begin
            data_out <= pix_data;
            row_idx  <= row;
         end

         if (state == S_XFER && data_ready && row_last)
            frame_cnt <= frame_cnt + 16'd1;
      end
   end

   // Strobes are pure decodes of the state register, so they are mutually exclusive.
   always_comb begin
      erase      = (state == S_ERASE);
      expose     = (state == S_EXPOSE);
      convert    = (state == S_CONVERT);
      ramp_code  = (state == S_CONVERT) ? cnt[DW-1:0] : '0;
      data_valid = (state == S_XFER);
      busy       = (state != S_IDLE);
      frame_done = (state == S_DONE);
      read       = '0;
      if (state == S_READ) read[row] = 1'b1;
   end

endmodule
